// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with memory
// ready handshakes, traps unknown opcodes and memory timeouts, counts retired instructions.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       Opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             IRWrite,
  output logic             ALUSrc,
  output logic [2:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             PCWrite,
  output logic [1:0]       pc_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam int                WAIT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_t;

  state_t            state, state_next;
  logic [6:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic is_lw, is_sw, is_br, is_jal, is_jalr, uses_imm, is_link;
  logic opcode_known, waiting, timed_out, retire;
  logic [2:0] alu_class;
  state_t     retire_target;

  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_br    = (op_q == OP_BR);
  assign is_jal   = (op_q == OP_JAL);
  assign is_jalr  = (op_q == OP_JALR);
  assign is_link  = is_jal | is_jalr;
  assign uses_imm = is_lw | is_sw | is_jalr | (op_q == OP_I);

  assign opcode_known = (Opcode == OP_R)  || (Opcode == OP_LW)  || (Opcode == OP_SW) ||
                        (Opcode == OP_I)  || (Opcode == OP_BR)  || (Opcode == OP_JAL) ||
                        (Opcode == OP_JALR);

  // A wait cycle is one with a memory request up and no ready; ready on the limit cycle still wins.
  assign waiting   = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
  assign timed_out = (TIMEOUT != 0) && waiting && (wait_cnt == WAIT_MAX);

  assign retire = ((state == S_EXEC) && is_br) ||
                  ((state == S_MEM) && is_sw && dmem_ready) ||
                  (state == S_WB);
  assign retire_target = run ? S_FETCH : S_IDLE;

  always_comb begin
    alu_class = 3'b000;
    case (op_q)
      OP_I, OP_JALR: alu_class = 3'b010;
      OP_LW:         alu_class = 3'b011;
      OP_SW:         alu_class = 3'b001;
      OP_BR:         alu_class = 3'b100;
      default:       alu_class = 3'b000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) op_q <= Opcode;
      if (waiting && (TIMEOUT != 0)) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                           wait_cnt <= '0;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  if (imem_ready)     state_next = S_DECODE;
                else if (timed_out) state_next = S_ERR;
      S_DECODE: state_next = opcode_known ? S_EXEC : S_ERR;
      S_EXEC:   if (is_br)              state_next = retire_target;
                else if (is_lw | is_sw) state_next = S_MEM;
                else                    state_next = S_WB;
      S_MEM:    if (dmem_ready)     state_next = is_lw ? S_WB : retire_target;
                else if (timed_out) state_next = S_ERR;
      S_WB:     state_next = retire_target;
      S_ERR:    state_next = S_ERR;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 3'b000;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 2'b00;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    pc_sel   = 2'b00;
    illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
      end
      S_EXEC: begin
        ALUSrc = uses_imm;
        ALUOp  = alu_class;
        if (is_br) begin
          PCWrite = 1'b1;
          pc_sel  = {1'b0, branch_taken};
        end else if (is_link) begin
          PCWrite = 1'b1;
          pc_sel  = is_jal ? 2'b10 : 2'b11;
        end
      end
      S_MEM: begin
        ALUSrc   = uses_imm;
        ALUOp    = alu_class;
        MemRead  = is_lw;
        MemWrite = is_sw;
        PCWrite  = is_sw && dmem_ready;
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = is_lw ? 2'b01 : (is_link ? 2'b10 : 2'b00);
        PCWrite  = !is_link;
      end
      S_ERR:   illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its expected per-cycle
// control trace from the opcode rules and memory wait counts, then replayed against the DUT.
module tb_multicycle_controller;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t       exp;
    logic [6:0] opcode;
    logic       taken;
    logic       iready;
    logic       dready;
    logic       run;
    logic       retire;
  } step_t;

  logic          clk, rst_n, run, branch_taken, imem_ready, dmem_ready;
  logic [6:0]    Opcode;
  logic          imem_req, IRWrite, ALUSrc, MemRead, MemWrite, RegWrite, PCWrite, illegal;
  logic [2:0]    ALUOp;
  logic [1:0]    MemtoReg, pc_sel;
  logic [CW-1:0] instret;
  ctl_t          dut_out;

  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] model_cnt;
  step_t         tr[$];

  multicycle_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .Opcode(Opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .IRWrite(IRWrite),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCWrite(PCWrite), .pc_sel(pc_sel),
    .illegal(illegal), .instret(instret)
  );

  assign dut_out = {imem_req, IRWrite, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg,
                    RegWrite, PCWrite, pc_sel, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs the DUT must ignore in a given cycle are randomised.
  function automatic step_t blank();
    step_t s;
    s.exp    = '0;
    s.opcode = 7'($urandom);
    s.taken  = 1'($urandom);
    s.iready = 1'($urandom);
    s.dready = 1'($urandom);
    s.run    = 1'($urandom);
    s.retire = 1'b0;
    return s;
  endfunction

  function automatic logic [2:0] alu_class(input logic [6:0] op);
    if (op == OP_I || op == OP_JALR) return 3'b010;
    if (op == OP_LW)                 return 3'b011;
    if (op == OP_SW)                 return 3'b001;
    if (op == OP_BR)                 return 3'b100;
    return 3'b000;
  endfunction

  function automatic void add_idle(input logic go);
    step_t s = blank();
    s.run = go;
    tr.push_back(s);
  endfunction

  function automatic void add_fetch(input int fw);
    step_t s;
    for (int i = 0; i < fw; i++) begin
      s = blank();
      s.exp.imem_req = 1'b1;
      s.iready = 1'b0;
      tr.push_back(s);
    end
    s = blank();
    s.exp.imem_req = 1'b1;
    s.exp.ir_write = 1'b1;
    s.iready = 1'b1;
    tr.push_back(s);
  endfunction

  function automatic void add_err(input int n);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s = blank();
      s.exp.illegal = 1'b1;
      tr.push_back(s);
    end
  endfunction

  // Expected trace of one instruction; its final step is always the retire cycle.
  function automatic void add_instr(input logic [6:0] op, input int fw, input int mw,
                                    input logic taken, input logic last);
    step_t s;
    logic lw, sw, br, jal, jalr;
    lw = (op == OP_LW); sw = (op == OP_SW); br = (op == OP_BR);
    jal = (op == OP_JAL); jalr = (op == OP_JALR);
    add_fetch(fw);
    s = blank();
    s.opcode = op;
    tr.push_back(s);
    s = blank();
    s.taken = taken;
    s.exp.alu_src = lw | sw | jalr | (op == OP_I);
    s.exp.alu_op  = alu_class(op);
    if (br) begin
      s.exp.pc_write = 1'b1;
      s.exp.pc_sel   = taken ? 2'b01 : 2'b00;
      s.retire = 1'b1;
      s.run    = !last;
    end else if (jal || jalr) begin
      s.exp.pc_write = 1'b1;
      s.exp.pc_sel   = jal ? 2'b10 : 2'b11;
    end
    tr.push_back(s);
    if (lw || sw) begin
      for (int i = 0; i <= mw; i++) begin
        s = blank();
        s.exp.alu_src   = 1'b1;
        s.exp.alu_op    = alu_class(op);
        s.exp.mem_read  = lw;
        s.exp.mem_write = sw;
        s.dready = (i == mw);
        if (sw && i == mw) begin
          s.exp.pc_write = 1'b1;
          s.retire = 1'b1;
          s.run    = !last;
        end
        tr.push_back(s);
      end
    end
    if (!br && !sw) begin
      s = blank();
      s.exp.reg_write  = 1'b1;
      s.exp.mem_to_reg = lw ? 2'b01 : ((jal || jalr) ? 2'b10 : 2'b00);
      s.exp.pc_write   = !(jal || jalr);
      s.retire = 1'b1;
      s.run    = !last;
      tr.push_back(s);
    end
  endfunction

  task automatic play(input string name);
    step_t s;
    int    idx = 0;
    while (tr.size() > 0) begin
      s = tr.pop_front();
      @(negedge clk);
      run          = s.run;
      Opcode       = s.opcode;
      branch_taken = s.taken;
      imem_ready   = s.iready;
      dmem_ready   = s.dready;
      #2;
      checks++;
      if (dut_out !== s.exp) begin
        failures++;
        $display("FAIL %s step %0d: controls=%h expected=%h", name, idx, dut_out, s.exp);
      end
      checks++;
      if (instret !== model_cnt) begin
        failures++;
        $display("FAIL %s step %0d: instret=%0d expected=%0d", name, idx, instret, model_cnt);
      end
      if (s.retire) model_cnt = model_cnt + 1'b1;
      idx++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    #2;
    checks++;
    if (dut_out !== ctl_t'(0) || instret !== '0) begin
      failures++;
      $display("FAIL reset: controls=%h instret=%0d expected all zero", dut_out, instret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = '0;
  endtask

  task automatic test_reset();
    do_reset();
    add_idle(0);
    add_idle(0);
    play("reset_idle");
  endtask

  task automatic test_r_type();
    add_idle(1);
    add_instr(OP_R, 0, 0, 1'b0, 1'b1);
    add_idle(0);
    play("r_type");
  endtask

  task automatic test_lw_wait();
    add_idle(1);
    add_instr(OP_LW, 0, 3, 1'b0, 1'b1);
    play("lw_wait");
  endtask

  task automatic test_branch();
    add_idle(1);
    add_instr(OP_BR, 0, 0, 1'b1, 1'b0);
    add_instr(OP_BR, 1, 0, 1'b0, 1'b1);
    play("branch");
  endtask

  task automatic test_jal_jalr();
    add_idle(1);
    add_instr(OP_JALR, 0, 0, 1'b0, 1'b0);
    add_instr(OP_JAL, 0, 0, 1'b0, 1'b0);
    add_instr(OP_SW, 0, 0, 1'b0, 1'b1);
    play("jal_jalr");
  endtask

  task automatic test_ready_boundary();
    add_idle(1);
    add_instr(OP_R, TO, 0, 1'b0, 1'b0);
    add_instr(OP_LW, 0, TO, 1'b0, 1'b0);
    add_instr(OP_SW, TO, TO, 1'b0, 1'b1);
    play("ready_at_limit");
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[7] = '{OP_R, OP_LW, OP_SW, OP_I, OP_BR, OP_JAL, OP_JALR};
    logic       last;
    add_idle(1);
    for (int n = 0; n < 40; n++) begin
      last = (n == 39) || ($urandom_range(0, 7) == 0);
      add_instr(ops[$urandom_range(0, 6)], $urandom_range(0, TO), $urandom_range(0, TO),
                1'($urandom), last);
      if (last && n != 39) begin
        add_idle(0);
        add_idle(1);
      end
    end
    play("back_to_back");
  endtask

  task automatic test_wrap();
    do_reset();
    add_idle(1);
    for (int n = 0; n < (1 << CW); n++) add_instr(OP_I, 0, 0, 1'b0, n == (1 << CW) - 1);
    add_idle(0);
    play("instret_wrap");
  endtask

  task automatic test_reset_mid_mem();
    step_t s;
    add_idle(1);
    add_instr(OP_R, 0, 0, 1'b0, 1'b0);
    add_fetch(0);
    s = blank();
    s.opcode = OP_SW;
    tr.push_back(s);
    s = blank();
    s.exp.alu_src = 1'b1;
    s.exp.alu_op  = 3'b001;
    tr.push_back(s);
    s = blank();
    s.exp.alu_src   = 1'b1;
    s.exp.alu_op    = 3'b001;
    s.exp.mem_write = 1'b1;
    s.dready = 1'b0;
    tr.push_back(s);
    play("pre_reset_mem");
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out !== ctl_t'(0)) begin
      failures++;
      $display("FAIL reset_mid_mem: controls=%h expected=0", dut_out);
    end
    checks++;
    if (instret !== '0) begin
      failures++;
      $display("FAIL reset_mid_mem: instret=%0d expected=0", instret);
    end
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    model_cnt = '0;
    add_idle(0);
    add_idle(1);
    add_instr(OP_R, 0, 0, 1'b0, 1'b1);
    play("after_reset_mid_mem");
  endtask

  task automatic test_illegal_opcode();
    step_t s;
    add_idle(1);
    add_instr(OP_I, 0, 0, 1'b0, 1'b0);
    add_fetch(1);
    s = blank();
    s.opcode = 7'b1111111;
    tr.push_back(s);
    add_err(5);
    play("illegal_opcode");
    do_reset();
  endtask

  task automatic test_timeout();
    step_t s;
    add_idle(1);
    for (int k = 0; k <= TO; k++) begin
      s = blank();
      s.exp.imem_req = 1'b1;
      s.iready = 1'b0;
      tr.push_back(s);
    end
    add_err(4);
    play("fetch_timeout");
    do_reset();
    add_idle(1);
    add_fetch(0);
    s = blank();
    s.opcode = OP_LW;
    tr.push_back(s);
    s = blank();
    s.exp.alu_src = 1'b1;
    s.exp.alu_op  = 3'b011;
    tr.push_back(s);
    for (int k = 0; k <= TO; k++) begin
      s = blank();
      s.exp.alu_src  = 1'b1;
      s.exp.alu_op   = 3'b011;
      s.exp.mem_read = 1'b1;
      s.dready = 1'b0;
      tr.push_back(s);
    end
    add_err(3);
    play("mem_timeout");
    do_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0; Opcode = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    model_cnt = '0;
    #12 rst_n = 1'b1;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branch();
    test_jal_jalr();
    test_ready_boundary();
    test_back_to_back();
    test_wrap();
    test_reset_mid_mem();
    test_illegal_opcode();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
